// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write port, a per-register
// busy scoreboard, optional same-cycle write bypass and a sequential bulk-clear engine.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    // state    | meaning
    // ST_IDLE  | normal operation: writes, reservations, bypass active
    // ST_CLEAR | sweeping one register per cycle, index in idx_q
    // ST_DONE  | sweep finished, clr_done pulses for this cycle
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int CNT_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    idx_q, idx_d;

    logic idle, wr_ok, rsv_ok;
    logic [DATA_W:0] rd_port1, rd_port2;

    // Extended by one bit so the compare stays meaningful when NUM_REGS == 2**ADDR_W.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < (ADDR_W+1)'(NUM_REGS);
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign idle     = (state_q == ST_IDLE);
    assign clr_busy = !idle;
    assign clr_done = (state_q == ST_DONE);
    assign wr_ok    = idle && wr_en && addr_ok(wr_addr) && !is_zero_reg(wr_addr);
    assign rsv_ok   = idle && rsv_en && addr_ok(rsv_addr) && !is_zero_reg(rsv_addr);

    // Returns {busy, data} for one read address.
    function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] a);
        logic [DATA_W:0] r;
        r = '0;
        if (addr_ok(a) && !is_zero_reg(a)) begin
            if ((BYPASS != 0) && wr_ok && (wr_addr == a)) begin
                r = {rsv_ok && (rsv_addr == a), wr_data};
            end else begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (a == ADDR_W'(i)) r = {busy_q[i], regs_q[i]};
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        rd_port1 = read_port(rd_addr1);
        rd_port2 = read_port(rd_addr2);
    end

    assign rd_data1 = rd_port1[DATA_W-1:0];
    assign rd_busy1 = rd_port1[DATA_W];
    assign rd_data2 = rd_port2[DATA_W-1:0];
    assign rd_busy2 = rd_port2[DATA_W];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (idx_q == CNT_W'(NUM_REGS - 1)) state_d = ST_DONE;
                else                               idx_d   = idx_q + 1'b1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Reservation is applied after the write so a same-cycle pair leaves busy set.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_ok && (wr_addr == ADDR_W'(i))) begin
                regs_d[i] = wr_data;
                busy_d[i] = 1'b0;
            end
            if (rsv_ok && (rsv_addr == ADDR_W'(i))) busy_d[i] = 1'b1;
            if ((state_q == ST_CLEAR) && (idx_q == CNT_W'(i))) begin
                regs_d[i] = '0;
                busy_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: three instances share one stimulus stream
// (default, BYPASS=0, NUM_REGS=24) and are checked with immediate assertions.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rd_addr1, rd_addr2, wr_addr, rsv_addr;
    logic [31:0] wr_data;
    logic        wr_en, rsv_en, clr_req;

    logic [31:0] rd_data1_a, rd_data2_a, rd_data1_b, rd_data2_b, rd_data1_c, rd_data2_c;
    logic        rd_busy1_a, rd_busy2_a, rd_busy1_b, rd_busy2_b, rd_busy1_c, rd_busy2_c;
    logic        clr_busy_a, clr_done_a, clr_busy_b, clr_done_b, clr_busy_c, clr_done_c;

    int compared = 0;
    int mismatched = 0;
    int busy_cnt_a, done_pos_a, busy_cnt_c, done_pos_c;

    always #5 clk = ~clk;

    regfile_sb dut_a (
        .clk(clk), .rst_n(rst_n), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1_a), .rd_data2(rd_data2_a), .rd_busy1(rd_busy1_a), .rd_busy2(rd_busy2_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .clr_req(clr_req), .clr_busy(clr_busy_a), .clr_done(clr_done_a)
    );

    regfile_sb #(.BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1_b), .rd_data2(rd_data2_b), .rd_busy1(rd_busy1_b), .rd_busy2(rd_busy2_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .clr_req(clr_req), .clr_busy(clr_busy_b), .clr_done(clr_done_b)
    );

    regfile_sb #(.NUM_REGS(24)) dut_c (
        .clk(clk), .rst_n(rst_n), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1_c), .rd_data2(rd_data2_c), .rd_busy1(rd_busy1_c), .rd_busy2(rd_busy2_c),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .clr_req(clr_req), .clr_busy(clr_busy_c), .clr_done(clr_done_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        compared++;
        assert (obs === want) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; rsv_en = 1'b0; clr_req = 1'b0;
        rd_addr1 = 5'd5; rd_addr2 = 5'd0; wr_addr = '0; rsv_addr = '0; wr_data = '0;
        #3;
        chk("rst_clr_busy", {31'd0, clr_busy_a}, 32'd0);
        chk("rst_clr_done", {31'd0, clr_done_a}, 32'd0);
        chk("rst_rd_data1", rd_data1_a, 32'd0);
        tick(); tick();
        rst_n = 1'b1;

        // write r5 then read it back; r6 stays zero
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_addr1 = 5'd6;
        #1 chk("rd_r6_during_wr", rd_data1_a, 32'd0);
        tick();
        wr_en = 1'b0; rd_addr1 = 5'd5; rd_addr2 = 5'd6;
        #1;
        chk("rd_r5_a", rd_data1_a, 32'hDEADBEEF);
        chk("rd_r5_busy_a", {31'd0, rd_busy1_a}, 32'd0);
        chk("rd_r5_b", rd_data1_b, 32'hDEADBEEF);
        chk("rd_r5_c", rd_data1_c, 32'hDEADBEEF);
        chk("rd_r6_a", rd_data2_a, 32'd0);

        // zero register
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rd_addr2 = 5'd0;
        #1;
        chk("r0_bypass_a", rd_data2_a, 32'd0);
        chk("r0_bypass_busy_a", {31'd0, rd_busy2_a}, 32'd0);
        tick();
        wr_en = 1'b0;
        #1;
        chk("r0_after_a", rd_data2_a, 32'd0);
        chk("r0_after_b", rd_data2_b, 32'd0);

        // bypass vs. no bypass
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hAAAA0000;
        tick();
        wr_data = 32'h12345678; rd_addr1 = 5'd7;
        #1;
        chk("byp_a", rd_data1_a, 32'h12345678);
        chk("nobyp_b", rd_data1_b, 32'hAAAA0000);
        chk("byp_c", rd_data1_c, 32'h12345678);
        tick();
        wr_en = 1'b0;
        #1 chk("nobyp_next_b", rd_data1_b, 32'h12345678);

        // scoreboard
        rsv_en = 1'b1; rsv_addr = 5'd9; rd_addr1 = 5'd9;
        tick();
        rsv_en = 1'b0;
        #1;
        chk("rsv_busy_a", {31'd0, rd_busy1_a}, 32'd1);
        chk("rsv_busy_b", {31'd0, rd_busy1_b}, 32'd1);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h00000099;
        #1;
        chk("wr_byp_busy_a", {31'd0, rd_busy1_a}, 32'd0);
        chk("wr_byp_data_a", rd_data1_a, 32'h00000099);
        chk("wr_nobyp_busy_b", {31'd0, rd_busy1_b}, 32'd1);
        tick();
        wr_en = 1'b0;
        #1;
        chk("wr_clr_busy_a", {31'd0, rd_busy1_a}, 32'd0);
        chk("wr_clr_busy_b", {31'd0, rd_busy1_b}, 32'd0);
        wr_en = 1'b1; wr_data = 32'h00001234; rsv_en = 1'b1;
        #1;
        chk("wr_rsv_byp_busy_a", {31'd0, rd_busy1_a}, 32'd1);
        chk("wr_rsv_byp_data_a", rd_data1_a, 32'h00001234);
        tick();
        wr_en = 1'b0; rsv_en = 1'b0;
        #1;
        chk("wr_rsv_busy_a", {31'd0, rd_busy1_a}, 32'd1);
        chk("wr_rsv_data_b", rd_data1_b, 32'h00001234);
        chk("wr_rsv_busy_b", {31'd0, rd_busy1_b}, 32'd1);

        // bulk clear: fill, reserve r3, pulse clr_req with a same-cycle write to r2
        wr_en = 1'b1;
        for (int i = 1; i < 32; i++) begin
            wr_addr = 5'(i); wr_data = 32'h100 + 32'(i);
            tick();
        end
        wr_en = 1'b0; rsv_en = 1'b1; rsv_addr = 5'd3;
        tick();
        rsv_en = 1'b0; rd_addr1 = 5'd31; rd_addr2 = 5'd23;
        #1;
        chk("fill_r31_a", rd_data1_a, 32'h0000011F);
        chk("fill_r31_invalid_c", rd_data1_c, 32'd0);
        chk("fill_r23_c", rd_data2_c, 32'h00000117);
        rd_addr1 = 5'd3;
        #1 chk("fill_r3_busy_a", {31'd0, rd_busy1_a}, 32'd1);
        clr_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'hBEEF0002;
        tick();
        clr_req = 1'b0; wr_en = 1'b0; rd_addr1 = 5'd2;
        #1 chk("clr_start_wr_r2_a", rd_data1_a, 32'hBEEF0002);

        busy_cnt_a = 0; done_pos_a = 0; busy_cnt_c = 0; done_pos_c = 0;
        for (int k = 0; k < 60 && (clr_busy_a || clr_busy_c); k++) begin
            if (clr_busy_a) busy_cnt_a++;
            if (clr_done_a) done_pos_a = busy_cnt_a;
            if (clr_busy_c) busy_cnt_c++;
            if (clr_done_c) done_pos_c = busy_cnt_c;
            if (k == 5) begin
                wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'hDEAD0001;
                rsv_en = 1'b1; rsv_addr = 5'd1; clr_req = 1'b1;
                rd_addr1 = 5'd1; rd_addr2 = 5'd20;
                #1;
                chk("mid_clr_r1_a", rd_data1_a, 32'd0);
                chk("mid_clr_r1_busy_a", {31'd0, rd_busy1_a}, 32'd0);
                chk("mid_clr_r20_a", rd_data2_a, 32'h00000114);
                chk("mid_clr_r20_c", rd_data2_c, 32'h00000114);
            end
            tick();
            if (k == 5) begin
                wr_en = 1'b0; rsv_en = 1'b0; clr_req = 1'b0;
            end
        end
        chk("clr_busy_cycles_a", busy_cnt_a, 32'd33);
        chk("clr_done_pos_a", done_pos_a, 32'd33);
        chk("clr_busy_cycles_c", busy_cnt_c, 32'd25);
        chk("clr_done_pos_c", done_pos_c, 32'd25);
        for (int i = 0; i < 32; i++) begin
            rd_addr1 = 5'(i);
            #1;
            chk($sformatf("post_clr_r%0d_a", i), {rd_busy1_a, rd_data1_a[30:0]} | {1'b0, rd_data1_a[31], 30'd0}, 32'd0);
            chk($sformatf("post_clr_r%0d_c", i), rd_data1_c, 32'd0);
        end

        // reset mid-clear
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h00000077;
        tick();
        wr_en = 1'b0; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick(); tick(); tick();
        rd_addr1 = 5'd5;
        #1 chk("pre_rst_r5_a", rd_data1_a, 32'h00000077);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy_a", {31'd0, clr_busy_a}, 32'd0);
        chk("rst_mid_busy_c", {31'd0, clr_busy_c}, 32'd0);
        chk("rst_mid_r5_a", rd_data1_a, 32'd0);
        chk("rst_mid_r5_c", rd_data1_c, 32'd0);
        #1 rst_n = 1'b1;
        tick();
        chk("post_rst_idle_c", {31'd0, clr_busy_c}, 32'd0);

        // invalid address on the 24-entry instance
        wr_en = 1'b1; wr_addr = 5'd30; wr_data = 32'h0000CAFE;
        rsv_en = 1'b1; rsv_addr = 5'd30; rd_addr1 = 5'd30;
        #1;
        chk("inv_byp_c", rd_data1_c, 32'd0);
        tick();
        wr_en = 1'b0; rsv_en = 1'b0;
        #1;
        chk("inv_rd_c", rd_data1_c, 32'd0);
        chk("inv_busy_c", {31'd0, rd_busy1_c}, 32'd0);
        chk("valid30_a", rd_data1_a, 32'h0000CAFE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
